// File: rtl/arb_perf_if.sv
// Request/grant/data bundle between the two switch interfaces, the arbiter
// and the selector path; the arbiter takes the slave view.
interface arb_perf_if #(
  parameter int W = 4
);
  logic         req_a;
  logic         req_b;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         grant_a;
  logic         grant_b;
  logic         en;
  logic         sel;
  logic [W-1:0] out_data;
  logic         busy;

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output grant_a, grant_b, en, sel, out_data, busy
  );

  modport master (
    output req_a, req_b, data_a, data_b,
    input  grant_a, grant_b, en, sel, out_data, busy
  );
endinterface

// File: rtl/arb_perf.sv
// Two-requester arbiter driving the shared selector path enable/select with a
// bounded grant and a turnaround gap. Define ARB_RR_EN for round-robin ties;
// otherwise A always wins ties.
module arb_perf #(
  parameter int HOLD = 8,
  parameter int W    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  arb_perf_if.slave  bus
);
  localparam int            CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_last, w_last_nxt;
  logic          r_sel, w_sel_nxt;
  logic          r_grant_a, r_grant_b, r_en, r_busy;
  logic          w_tie_b;

  // next-state, hold counter and round-robin pointer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
`ifdef ARB_RR_EN
    w_tie_b     = ~r_last;
`else
    w_tie_b     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.req_a && (!bus.req_b || !w_tie_b)) begin
          w_state_nxt = S_GNT_A;
          w_cnt_nxt   = CW'(1);
          w_last_nxt  = 1'b0;
          w_sel_nxt   = 1'b0;
        end else if (bus.req_b) begin
          w_state_nxt = S_GNT_B;
          w_cnt_nxt   = CW'(1);
          w_last_nxt  = 1'b1;
          w_sel_nxt   = 1'b1;
        end
      end
      S_GNT_A: begin
        if (!bus.req_a || r_cnt == HOLD_C) w_state_nxt = S_GAP;
        else                               w_cnt_nxt   = r_cnt + CW'(1);
      end
      S_GNT_B: begin
        if (!bus.req_b || r_cnt == HOLD_C) w_state_nxt = S_GAP;
        else                               w_cnt_nxt   = r_cnt + CW'(1);
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // registered state and outputs; reset drops the path with no gap cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_sel     <= 1'b0;
      r_grant_a <= 1'b0;
      r_grant_b <= 1'b0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_sel     <= w_sel_nxt;
      r_grant_a <= (w_state_nxt == S_GNT_A);
      r_grant_b <= (w_state_nxt == S_GNT_B);
      r_en      <= (w_state_nxt == S_GNT_A) || (w_state_nxt == S_GNT_B);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.grant_a  = r_grant_a;
  assign bus.grant_b  = r_grant_b;
  assign bus.en       = r_en;
  assign bus.sel      = r_sel;
  assign bus.busy     = r_busy;
  assign bus.out_data = {W{r_en}} & (r_sel ? bus.data_b : bus.data_a);
endmodule
